// File: rtl/cdc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdc_pkg : shared CDC constants, Gray helpers, filter counter sizing  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cdc_pkg;

  localparam int CDC_MIN_STAGES = 2;
  localparam int CDC_MAX_WIDTH  = 64;

  // Counter must reach STABLE_CNT-1; never narrower than one bit.
  function automatic int cdc_cnt_width(input int stable_cnt);
    int w;
    w = $clog2(stable_cnt);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic logic [CDC_MAX_WIDTH-1:0] gray2bin(input logic [CDC_MAX_WIDTH-1:0] g);
    logic [CDC_MAX_WIDTH-1:0] b;
    b[CDC_MAX_WIDTH-1] = g[CDC_MAX_WIDTH-1];
    for (int i = CDC_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [CDC_MAX_WIDTH-1:0] bin2gray(input logic [CDC_MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_sync_chain.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdc_sync_chain : STAGES-deep flop synchroniser for a SIZE-bit bus    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cdc_sync_chain #(
  parameter int SIZE   = 1,
  parameter int STAGES = 2
) (
  input  logic            clkb,
  input  logic            rstb,
  input  logic [SIZE-1:0] d,
  output logic [SIZE-1:0] q
);

  logic [STAGES-1:0][SIZE-1:0] r_s;

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_s <= '0;
    end else begin
      r_s <= {r_s[STAGES-2:0], d};
    end
  end

  assign q = r_s[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_bus_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cdc_bus_sync : bus synchroniser with stability filter; define        |
// | CDC_BUS_GRAY_EN for unfiltered Gray-counter transfer.  Revision: 1.0 |
// +----------------------------------------------------------------------+
module cdc_bus_sync
  import cdc_pkg::*;
#(
  parameter int SIZE       = 1,
  parameter int STAGES     = 2,
  parameter int STABLE_CNT = 3
) (
  input  logic            clkb,
  input  logic            rstb,
  input  logic [SIZE-1:0] siga,
  output logic [SIZE-1:0] sigb,
  output logic            sigb_upd,
  output logic            busy
);

  generate
    if (STAGES < CDC_MIN_STAGES || STABLE_CNT < 1 || SIZE < 1 || SIZE > CDC_MAX_WIDTH) begin : g_bad_param
      $error("cdc_bus_sync: illegal SIZE/STAGES/STABLE_CNT");
    end
  endgenerate

  logic [SIZE-1:0] w_slast;

  cdc_sync_chain #(
    .SIZE   (SIZE),
    .STAGES (STAGES)
  ) u_chain (
    .clkb (clkb),
    .rstb (rstb),
    .d    (siga),
    .q    (w_slast)
  );

`ifdef CDC_BUS_GRAY_EN

  // Single-bit-change source: the synchronised code is always coherent.
  logic [SIZE-1:0] w_bin;

  assign w_bin = SIZE'(gray2bin(CDC_MAX_WIDTH'(w_slast)));

  always_ff @(posedge clkb) begin
    if (rstb) begin
      sigb     <= '0;
      sigb_upd <= 1'b0;
    end else begin
      sigb     <= w_bin;
      sigb_upd <= (w_bin != sigb);
    end
  end

  assign busy = 1'b0;

`else

  localparam int              CW        = cdc_cnt_width(STABLE_CNT);
  localparam logic [CW-1:0]   c_cnt_max = CW'(STABLE_CNT - 1);

  logic [SIZE-1:0] r_prev;
  logic [CW-1:0]   r_cnt;
  logic            w_same;
  logic            w_upd;

  assign w_same = (w_slast == r_prev);
  assign w_upd  = w_same && (r_cnt == c_cnt_max) && (w_slast != sigb);

  always_ff @(posedge clkb) begin
    if (rstb) begin
      r_prev   <= '0;
      r_cnt    <= '0;
      sigb     <= '0;
      sigb_upd <= 1'b0;
    end else begin
      r_prev <= w_slast;
      if (!w_same) begin
        r_cnt <= '0;
      end else if (r_cnt < c_cnt_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_upd) begin
        sigb <= w_slast;
      end
      sigb_upd <= w_upd;
    end
  end

  assign busy = (w_slast != sigb);

`endif

endmodule
`default_nettype wire

// File: doc/cdc_bus_sync.md
Name: cdc_bus_sync

Overview:
- Parametrised successor to the single-level double-flop synchroniser.
- Moves a multi-bit, quasi-static control/status bus (e.g. band select, attenuator, PTT flags) into the clkb domain through a configurable-depth sync chain.
- Adds a stability filter, so the output updates only after the synchronised value has held for STABLE_CNT cycles. This prevents capture of torn multi-bit words.
- Emits a one-cycle update strobe and a busy flag for downstream logic.

Parameters:
- SIZE, 1: bus width in bits, ≥1.
- STAGES, 2: synchroniser flop depth, ≥2.
- STABLE_CNT, 3: consecutive equal synchronised samples required before update, ≥1.

Ports:
- clkb  in  1  destination clock
- rstb  in  1  reset, synchronous, active-high
- siga  in  SIZE  asynchronous source bus
- sigb  out  SIZE  filtered synchronised bus
- sigb_upd  out  1  single-cycle pulse, high in the cycle sigb takes a new value
- busy  out  1  high while the synchronised value differs from sigb

Behaviour:
- Reset: all sync stages, prev, cnt, sigb and sigb_upd are cleared to 0. busy evaluates to 0.
- Reset is sampled on clkb edges only. Asserting rstb mid-filter discards any pending value. After release, the filter restarts from 0, so an all-zero siga causes no update.
- Sync chain: s[0] <= siga; s[i] <= s[i-1]; s_last = s[STAGES-1].
- prev <= s_last every cycle.
- Counter cnt:
  - Width max(1, clog2(STABLE_CNT)).
  - If s_last != prev, cnt <= 0.
  - Else if cnt < STABLE_CNT-1, cnt <= cnt+1.
  - Otherwise cnt saturates.
- Update condition: s_last == prev, cnt == STABLE_CNT-1 and s_last != sigb.
  - When true, sigb <= s_last and sigb_upd <= 1.
  - Otherwise sigb holds and sigb_upd <= 0.
- Latency:
  - A siga change set up before edge 1 and held steady appears on sigb after edge STAGES+STABLE_CNT+1.
  - sigb_upd is high for exactly that one cycle.
- Glitch/toggle: any change of s_last restarts the count. A value that does not persist STABLE_CNT+1 consecutive s_last samples is never output.
- Return to old value: if siga changes then reverts before the filter completes, there is no update and no pulse.
- Continuous toggling faster than the filter: sigb holds its last stable value indefinitely and busy stays high.
- Back-to-back stable changes: each produces its own single-cycle pulse, separated by at least STABLE_CNT+1 cycles.
- busy = (s_last != sigb), combinational from registers.

Optional Feature:
- Macro: CDC_BUS_GRAY_EN.
- When defined:
  - siga is a Gray-coded counter and only one bit changes per step.
  - The stability filter, prev and cnt are removed.
  - Every cycle sigb <= gray2bin(s_last).
  - sigb_upd <= (gray2bin(s_last) != sigb).
  - Latency is STAGES+1 edges.
  - busy is tied to 0.
  - STABLE_CNT is ignored.
- When undefined: the filtered behaviour above applies and no Gray logic is synthesised.

Decomposition:
- Package cdc_pkg holds:
  - the gray2bin and bin2gray functions;
  - constant CDC_MIN_STAGES = 2;
  - a helper computing counter width from STABLE_CNT.
- Sub-module cdc_sync_chain (parameters SIZE, STAGES; ports clkb, rstb, d, q) implements the flop chain. It is reusable by other CDC blocks.
- Elaboration-time check: STAGES ≥ CDC_MIN_STAGES and STABLE_CNT ≥ 1.

Test Plan:
- Reset check: SIZE=8, STAGES=2, STABLE_CNT=3; rstb high for 4 cycles with siga=8'hA5 → sigb=0, sigb_upd=0, busy=0 during reset.
- Basic latency: after reset release, siga steps 8'h00→8'h3C and holds → sigb=8'h3C exactly at edge 6 after the change, sigb_upd high that single cycle, busy high edges 2–5.
- Glitch rejection: siga 8'h3C→8'hFF for 2 cycles, then back to 8'h3C → sigb stays 8'h3C and no sigb_upd.
- Persistent toggle: siga alternates 8'h01/8'h02 every cycle for 50 cycles → no update; busy high; after holding 8'h02, update at the 6th edge.
- Reset mid-filter: siga→8'h77, rstb pulsed at edge 4 → sigb=0 and no pulse. Post-reset, sigb=8'h77 at edge 6 after release.
- Gray mode (CDC_BUS_GRAY_EN, SIZE=4): drive a Gray count 0..15 once every 4 clkb cycles → sigb follows binary 0..15 with 3-edge latency, one pulse per step, and wraps 15→0 with a pulse.
